// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised RAM with zero-fill sweep.
//   state_t     : sweep controller states
//   READ_FIRST  : same-address write returns the old word on qout
//   WRITE_FIRST : same-address write returns the new word on qout
package mem_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SWEEP = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

endpackage

// File: rtl/mem_clr_fsm.sv
// Zero-fill controller: owns the state machine, the sweep counter and busy.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_clr           : zero-fill request, honoured only in READY
//   o_busy          : registered, high from reset until the sweep completes
//   o_ready_c       : user accesses allowed this cycle
//   o_sweep_sel_c   : write port is owned by the sweep this cycle
//   o_sweep_addr_c  : address the sweep writes this cycle
module mem_clr_fsm
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_ready_c,
  output logic              o_sweep_sel_c,
  output logic [ADDR_W-1:0] o_sweep_addr_c
);

  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'((1 << ADDR_W) - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // State, counter and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic; the counter parks on the terminal count instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        w_state_nxt = SWEEP;
        w_cnt_nxt   = '0;
      end
      SWEEP: begin
        if (r_cnt == TERM) begin
          w_state_nxt = READY;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      READY: begin
        if (i_clr) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
    // busy is registered from the next state so it falls on the edge entering READY.
    w_busy_nxt = (w_state_nxt != READY);
  end

  assign o_busy         = r_busy;
  assign o_ready_c      = (r_state == READY);
  assign o_sweep_sel_c  = (r_state == SWEEP);
  assign o_sweep_addr_c = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/mem_ram_param.sv
// Single-clock RAM with registered read data and a hardware zero-fill sweep
// after reset and on request.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : access enable
//   WEn        : write enable (with en)
//   addr, data : word address, write data
//   clr        : one-cycle zero-fill request
//   qout       : registered read data (0 while busy)
//   busy       : zero-fill sweep in progress
module mem_ram_param
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RD_MODE = READ_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              WEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic [DATA_W-1:0] qout,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          WR_FIRST = (RD_MODE == WRITE_FIRST);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_qout;
  logic              w_busy;
  logic              w_ready;
  logic              w_sweep_sel;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_user_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  mem_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (clr),
    .o_busy         (w_busy),
    .o_ready_c      (w_ready),
    .o_sweep_sel_c  (w_sweep_sel),
    .o_sweep_addr_c (w_sweep_addr)
  );

  // A clear request wins over a user write presented in the same cycle.
  assign w_user_we = w_ready & en & WEn & ~clr;

  // Single write port shared between the sweep and the user.
  assign w_we    = w_sweep_sel | w_user_we;
  assign w_waddr = w_sweep_sel ? w_sweep_addr : addr;
  assign w_wdata = w_sweep_sel ? '0 : data;

  // Array write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read register: forced to 0 outside READY and on the clear edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qout <= '0;
    end else if (!w_ready || clr) begin
      r_qout <= '0;
    end else if (en) begin
      if (WEn && WR_FIRST) begin
        r_qout <= data;
      end else begin
        r_qout <= r_mem[addr];
      end
    end
  end

  assign qout = r_qout;
  assign busy = w_busy;

endmodule

// File: tb/tb_mem_ram_param.sv
// Bench: two 16x256 instances (READ_FIRST / WRITE_FIRST) sharing stimulus,
// plus a 32x16 instance for the narrow-address configuration.
module tb_mem_ram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, we, clr;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [15:0] q0, q1;
  logic        busy0, busy1;

  logic        en2, we2, clr2;
  logic [3:0]  addr2;
  logic [31:0] data2;
  logic [31:0] q2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [256];
  logic [15:0] exp_rf, exp_wf;

  always #5 clk = ~clk;

  mem_ram_param #(.DATA_W(16), .ADDR_W(8), .RD_MODE(mem_pkg::READ_FIRST)) u_rf (
    .clk(clk), .rst_n(rst_n), .en(en), .WEn(we), .addr(addr), .data(data),
    .clr(clr), .qout(q0), .busy(busy0));

  mem_ram_param #(.DATA_W(16), .ADDR_W(8), .RD_MODE(mem_pkg::WRITE_FIRST)) u_wf (
    .clk(clk), .rst_n(rst_n), .en(en), .WEn(we), .addr(addr), .data(data),
    .clr(clr), .qout(q1), .busy(busy1));

  mem_ram_param #(.DATA_W(32), .ADDR_W(4), .RD_MODE(mem_pkg::READ_FIRST)) u_nar (
    .clk(clk), .rst_n(rst_n), .en(en2), .WEn(we2), .addr(addr2), .data(data2),
    .clr(clr2), .qout(q2), .busy(busy2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; data = '0;
  endtask

  // After a completed sweep every word is zero and qout reads zero.
  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    exp_rf = '0;
    exp_wf = '0;
  endtask

  // One user cycle on the shared 16-bit instances, checked against the model.
  task automatic do_op(input logic e, input logic w, input logic [7:0] a, input logic [15:0] d);
    en = e; we = w; addr = a; data = d; clr = 1'b0;
    if (e) begin
      exp_rf = mem_m[a];
      exp_wf = w ? d : mem_m[a];
      if (w) mem_m[a] = d;
    end
    step();
    chk("q_read_first", 64'(q0), 64'(exp_rf));
    chk("q_write_first", 64'(q1), 64'(exp_wf));
    chk("busy_ready", 64'(busy0), 64'(0));
  endtask

  // Edges until busy of the wide instances falls (and of the narrow one);
  // optionally hammers the inputs with accesses and clears that must be ignored.
  task automatic count_busy(input bit garbage, output int n0, output int n2);
    n0 = -1;
    n2 = -1;
    for (int i = 1; i <= 400; i++) begin
      if (garbage) begin
        en = 1'b1; we = 1'b1; addr = 8'($urandom); data = 16'($urandom);
        clr = 1'($urandom_range(0, 1));
      end
      step();
      chk("q_zero_sweep", 64'(q0), 64'(0));
      if (!busy2 && n2 < 0) n2 = i;
      if (!busy0) begin
        n0 = i;
        break;
      end
    end
    idle();
  endtask

  int n0, n2;

  initial begin
    rst_n = 1'b0;
    idle();
    en2 = 1'b0; we2 = 1'b0; clr2 = 1'b0; addr2 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q0", 64'(q0), 64'(0));
    chk("rst_busy0", 64'(busy0), 64'(1));
    chk("rst_q1", 64'(q1), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(1));
    chk("rst_q2", 64'(q2), 64'(0));
    chk("rst_busy2", 64'(busy2), 64'(1));

    // Release reset: INIT + full sweep, with ignored traffic and clears.
    rst_n = 1'b1;
    #1;
    chk("init_busy", 64'(busy0), 64'(1));
    count_busy(1'b1, n0, n2);
    chk("sweep_len_256", 64'(n0), 64'(257));
    chk("sweep_len_16", 64'(n2), 64'(17));
    model_clear();

    do_op(1'b1, 1'b0, 8'h84, 16'h0);
    chk("rd_84_zero", 64'(q0), 64'h0);

    // Directed writes then read-back.
    do_op(1'b1, 1'b1, 8'h01, 16'h0001);
    do_op(1'b1, 1'b1, 8'h02, 16'h0010);
    do_op(1'b1, 1'b1, 8'h84, 16'h0006);
    do_op(1'b1, 1'b1, 8'h48, 16'h0012);
    do_op(1'b1, 1'b0, 8'h01, 16'h0);
    chk("rd_01", 64'(q0), 64'h0001);
    do_op(1'b1, 1'b0, 8'h02, 16'h0);
    chk("rd_02", 64'(q0), 64'h0010);
    do_op(1'b1, 1'b0, 8'h84, 16'h0);
    chk("rd_84", 64'(q0), 64'h0006);
    do_op(1'b1, 1'b0, 8'h48, 16'h0);
    chk("rd_48", 64'(q0), 64'h0012);

    // Same-address write behaviour for both read modes.
    do_op(1'b1, 1'b1, 8'h84, 16'hBEEF);
    chk("rf_during_wr", 64'(q0), 64'h0006);
    chk("wf_during_wr", 64'(q1), 64'hBEEF);
    do_op(1'b0, 1'b0, 8'h84, 16'h5555);
    chk("hold_en0", 64'(q0), 64'h0006);
    do_op(1'b1, 1'b0, 8'h84, 16'h0);
    chk("rd_beef_rf", 64'(q0), 64'hBEEF);
    chk("rd_beef_wf", 64'(q1), 64'hBEEF);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_op(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // Narrow instance: write, read, clear, read.
    en2 = 1'b1; we2 = 1'b1; addr2 = 4'hF; data2 = 32'hA5A5A5A5;
    step();
    chk("nar_rf_wr", 64'(q2), 64'h0);
    we2 = 1'b0;
    step();
    chk("nar_rd", 64'(q2), 64'hA5A5A5A5);
    en2 = 1'b0; clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("nar_clr_busy", 64'(busy2), 64'(1));
    chk("nar_clr_q", 64'(q2), 64'h0);
    n2 = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (!busy2) begin
        n2 = i;
        break;
      end
    end
    chk("nar_sweep_len", 64'(n2), 64'(16));
    en2 = 1'b1; addr2 = 4'hF;
    step();
    chk("nar_rd_cleared", 64'(q2), 64'h0);
    en2 = 1'b0;

    // Clear together with a write: the write is dropped.
    do_op(1'b1, 1'b1, 8'h01, 16'h0001);
    en = 1'b1; we = 1'b1; addr = 8'h10; data = 16'h1234; clr = 1'b1;
    step();
    idle();
    chk("clr_busy", 64'(busy0), 64'(1));
    chk("clr_q", 64'(q0), 64'h0);
    count_busy(1'b1, n0, n2);
    chk("clr_sweep_len", 64'(n0), 64'(256));
    model_clear();
    do_op(1'b1, 1'b0, 8'h10, 16'h0);
    chk("rd_10_cleared", 64'(q0), 64'h0);
    do_op(1'b1, 1'b0, 8'h01, 16'h0);
    chk("rd_01_cleared", 64'(q0), 64'h0);

    // Asynchronous reset in the middle of an access.
    do_op(1'b1, 1'b1, 8'h05, 16'hABCD);
    do_op(1'b1, 1'b0, 8'h05, 16'h0);
    chk("rd_05", 64'(q0), 64'hABCD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q0", 64'(q0), 64'h0);
    chk("async_q1", 64'(q1), 64'h0);
    chk("async_busy", 64'(busy0), 64'(1));
    repeat (2) step();
    rst_n = 1'b1;
    count_busy(1'b1, n0, n2);
    chk("rst_access_sweep_len", 64'(n0), 64'(257));
    model_clear();

    // Reset in the middle of a sweep restarts a full sweep.
    do_op(1'b1, 1'b1, 8'h33, 16'h7777);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (100) step();
    rst_n = 1'b0;
    #1;
    chk("midsweep_busy", 64'(busy0), 64'(1));
    chk("midsweep_q", 64'(q0), 64'h0);
    repeat (2) step();
    rst_n = 1'b1;
    count_busy(1'b1, n0, n2);
    chk("midsweep_len", 64'(n0), 64'(257));
    model_clear();
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 8'($urandom), 16'h0);
    do_op(1'b1, 1'b0, 8'h33, 16'h0);
    do_op(1'b1, 1'b1, 8'hFF, 16'hC0DE);
    do_op(1'b1, 1'b0, 8'hFF, 16'h0);
    chk("rd_ff", 64'(q0), 64'hC0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ram_param.md
MEM_RAM_PARAM -- requirements
Module: mem_ram_param

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default READ_FIRST: same-address read/write policy, READ_FIRST or WRITE_FIRST.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  access enable; no read or write occurs when low.
REQ-007 WEn  input  1  write enable, active-high; a write occurs when en=1 and WEn=1.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 data  input  DATA_W  write data.
REQ-010 clr  input  1  single-cycle pulse requesting a zero-fill of the whole array.
REQ-011 qout  output  DATA_W  registered read data.
REQ-012 busy  output  1  high while a zero-fill sweep is in progress.

Function
REQ-013 FSM states: INIT, SWEEP, READY.
- INIT lasts one cycle after rst_n deasserts, then goes to SWEEP.
- SWEEP writes 0 to one address per cycle, counting from 0 to DEPTH-1, then goes to READY.
- READY serves user accesses.
REQ-014 A full sweep lasts exactly DEPTH cycles with busy=1 throughout; busy drops in the cycle the FSM enters READY.
REQ-015 While busy=1, en, WEn, addr, data and clr are ignored; qout holds 0.
REQ-016 In READY, en=1 and WEn=0 loads qout with mem[addr] at the next edge (read latency 1 cycle).
REQ-017 In READY, en=1 and WEn=1 writes data to mem[addr] at the edge. qout then takes:
- old mem[addr] if RD_MODE=READ_FIRST;
- data if RD_MODE=WRITE_FIRST.
REQ-018 With en=0, qout holds its previous value and the memory is unchanged.
REQ-019 clr=1 in READY enters SWEEP at the next edge; a write presented in the same cycle is dropped.
REQ-020 clr asserted during SWEEP has no effect; the sweep is not restarted.
REQ-021 The sweep counter is ADDR_W+1 bits wide; the terminal count is DEPTH-1 and the counter does not wrap into address 0 after it.
REQ-022 Address wrap for user accesses is natural modulo DEPTH; no out-of-range case exists.

Reset
REQ-023 rst_n=0 forces, asynchronously: state INIT, sweep counter 0, qout=0, busy=1.
REQ-024 The memory array has no reset; its contents are defined only by the sweep.
REQ-025 rst_n asserted mid-sweep or mid-access aborts the operation; a fresh full sweep starts after deassertion.

Structure
REQ-026 Shared package mem_pkg holds:
- the FSM state typedef (INIT, SWEEP, READY);
- the RD_MODE constants READ_FIRST=0 and WRITE_FIRST=1.
REQ-027 Sub-module mem_clr_fsm holds the FSM, the sweep counter and busy, and drives the internal write-port mux select; the array and the qout register stay in mem_ram_param.
REQ-028 The array is inferred as synchronous block RAM with one write port and one read port, both on clk.

Verification
REQ-029 Default parameters, release rst_n -> busy=1 for exactly 257 cycles (INIT + 256); then read addr 0x84 returns qout=0x0000.
REQ-030 Write 0x0001@0x01, 0x0010@0x02, 0x0006@0x84, 0x0012@0x48; then read each address -> matching value one cycle after each read.
REQ-031 RD_MODE=READ_FIRST: 0x0006@0x84 then write 0xBEEF@0x84 -> qout=0x0006 during the write, 0xBEEF on the next read. With RD_MODE=WRITE_FIRST -> qout=0xBEEF during the write.
REQ-032 clr pulsed together with a write of 0x1234@0x10 -> busy=1 for 256 cycles; afterwards 0x10 and 0x01 both read 0x0000.
REQ-033 rst_n pulsed low at sweep cycle 100 -> qout=0 and busy=1 immediately; the sweep restarts, busy stays high 257 cycles after release, and no writes are accepted until it ends.
REQ-034 DATA_W=32, ADDR_W=4: write 0xA5A5A5A5@0xF, clr, read 0xF -> 0x00000000; the sweep lasts 16 cycles.
